apf_wishbone_ram_slave: RTL and testbench
=========================================

# apf_wishbone_ram_slave

Wishbone B4 registered-feedback responder on `clk_sys` that fronts a single-port on-chip RAM window. It is the target end of the bus driven by the APF bridge Wishbone master, so bridge reads and writes can land in local block RAM without SDRAM. It supports classic cycles, linear incrementing bursts and byte-lane writes, and it flags out-of-window or unsupported accesses with `err`.

## Interface
- `ADDR_WORDS_LOG2`, 8: RAM depth is 2^N 32-bit words.
- `BASE_ADDR`, 30'h0: word address of RAM word 0 on the bus.
- `WAIT_STATES`, 0: extra cycles inserted before each classic ack, range 0..7.

Ports:
- `clk_sys` in 1: system clock; everything here is on this one clock.
- `reset_n` in 1: reset, asynchronous assert, active-low.
- `addr` in 30: word address.
- `data_write` in 32: write data.
- `sel` in 4: byte enables; bit i gates byte [8i+7:8i].
- `cyc`, `stb`, `we` in 1 each: Wishbone cycle, strobe and write enable.
- `cti` in 3: 000 classic, 010 incrementing burst, 111 end-of-burst.
- `bte` in 2: burst extension. Only 00 (linear) is supported.
- `data_read` out 32: read data. Valid only while `ack`=1.
- `ack` out 1: one-cycle-per-beat acknowledge.
- `err` out 1: error termination.
- `access_count` out 16: completed acked beats, wraps at 0xFFFF→0.

## Operation
- Reset values: `ack`=0, `err`=0, `data_read`=0, `access_count`=0, state IDLE. Reset does not clear RAM contents.
- Window hit: `addr - BASE_ADDR < 2^ADDR_WORDS_LOG2`, computed unsigned in 30 bits. Index is the low `ADDR_WORDS_LOG2` bits of the difference.
- States:
  - IDLE: on `cyc & stb`:
    - miss, or `cti`=010 with `bte`≠00: go to ERR.
    - `cti`=010: go to BURST.
    - otherwise: go to WAIT if `WAIT_STATES`>0, else ACK.
  - WAIT: count `WAIT_STATES` cycles, then go to ACK.
  - ACK: drive `ack`=1 for one cycle, then go to DEAD.
  - BURST: `ack`=1 on every cycle in which `cyc & stb` is high. The internal index starts at the latched index and increments by 1 per acked beat. `addr` is ignored after the first beat. The beat with `cti`=111 is the last; go to DEAD after it. A beat whose index wraps past the window end terminates with `err` instead of `ack`; go to DEAD.
  - ERR: drive `err`=1 for one cycle; no RAM access; go to DEAD.
  - DEAD: `ack`=`err`=0 for one cycle, then IDLE. This keeps a strobe the master has not yet dropped from being double-acked.
- Writes commit to RAM in the cycle `ack` is high, for enabled bytes only. `sel`=0 still acks with no change.
- Reads return the RAM word, registered, in the `ack` cycle.
- `access_count` increments once per acked beat, reads and writes alike. Error beats are not counted.
- Abort: `cyc`=0 in WAIT, ACK-pending or BURST returns to IDLE next cycle. No further ack, and no write for an unacked beat.
- Async reset mid-transaction: outputs go to reset values immediately. An in-flight write beat not yet clocked is dropped.

## Timing
- Classic: strobe sampled in cycle T; `ack` in T+1+`WAIT_STATES`; next strobe accepted at T+3+`WAIT_STATES` at the earliest.
- Burst: first ack at T+1, then one beat per cycle while `stb` is high. `stb` low pauses without leaving BURST.
- `ack` and `err` are never high together, and each is never high for more than one cycle outside BURST.
- RAM is inferred single-port with one-cycle read latency. The read address is presented in the cycle before the ack.

## Test plan
- Classic write 0xDEADBEEF, `sel`=F, to BASE+3; read back → `ack` 1 cycle after strobe, `data_read`=0xDEADBEEF, `access_count`=2.
- Byte-lane write 0x000000AA, `sel`=0001, over 0x11223344 → readback 0x112233AA.
- Read at BASE+2^N → `err`=1 for one cycle, `ack` never asserted, `access_count` unchanged.
- 4-beat burst read from BASE+4 (`cti` 010,010,010,111), `stb` dropped for 2 cycles after beat 2 → four acks with data of words 4..7 in order, no ack during the pause, DEAD then IDLE.
- `WAIT_STATES`=3 classic read → `ack` exactly 4 cycles after strobe. Drop `cyc` in the second wait cycle → no ack, and a later write to the same word is unaffected.
- Assert `reset_n`=0 during a burst write beat → `ack`/`err`/`access_count` at 0 in the same cycle. After release, a classic read is serviced normally from IDLE.

Source files
------------

// File: rtl/apf_wishbone_ram_slave.sv
// Wishbone B4 registered-feedback responder fronting a single-port block RAM window.
// Supports classic cycles with optional wait states, linear incrementing bursts and byte-lane writes.
module apf_wishbone_ram_slave #(
    parameter int          ADDR_WORDS_LOG2 = 8,
    parameter logic [29:0] BASE_ADDR       = 30'h0,
    parameter int          WAIT_STATES     = 0
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [29:0] addr,
    input  logic [31:0] data_write,
    input  logic [3:0]  sel,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [2:0]  cti,
    input  logic [1:0]  bte,
    output logic [31:0] data_read,
    output logic        ack,
    output logic        err,
    output logic [15:0] access_count
);
    // state   | meaning
    // S_IDLE  | waiting for cyc & stb
    // S_WAIT  | classic access, counting wait states
    // S_ACK   | ack high for the final (or only) beat
    // S_BURST | incrementing burst, ack follows every strobed cycle
    // S_ERR   | err high for one cycle
    // S_DEAD  | ack/err low for one cycle so a lingering strobe is not re-acked

    localparam int         AW       = ADDR_WORDS_LOG2;
    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;
    localparam logic [AW:0] IDX_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_BURST, S_ERR, S_DEAD} state_t;

    state_t      state;
    logic [31:0] ram [0:2**AW-1];
    logic [31:0] ram_q;
    logic [29:0] offset;
    logic        hit;
    logic        req;
    logic [AW:0] idx_q;
    logic [2:0]  wait_cnt;
    logic        beat_fire;
    logic        err_fire;
    logic [AW-1:0] ram_idx;
    logic [3:0]  ram_we;

    assign offset = addr - BASE_ADDR;
    assign hit    = (offset >> AW) == 30'd0;
    assign req    = cyc & stb;

    // beat_fire marks the edge that launches an ack; the RAM is accessed on that same edge.
    always_comb begin
        beat_fire = 1'b0;
        err_fire  = 1'b0;
        ram_idx   = idx_q[AW-1:0];
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (!hit || (cti == CTI_INCR && bte != 2'b00)) begin
                        err_fire = 1'b1;
                    end else if (cti == CTI_INCR || WAIT_STATES == 0) begin
                        beat_fire = 1'b1;
                        ram_idx   = offset[AW-1:0];
                    end
                end
            end
            S_WAIT: begin
                if (cyc && wait_cnt == 3'd0) beat_fire = 1'b1;
            end
            S_BURST: begin
                // idx_q MSB set means the previous beat was the last word of the window
                if (req) begin
                    if (idx_q[AW]) err_fire = 1'b1;
                    else           beat_fire = 1'b1;
                end
            end
            default: ;
        endcase
        if (!reset_n) begin
            beat_fire = 1'b0;
            err_fire  = 1'b0;
        end
    end

    assign ram_we = (beat_fire && we) ? sel : 4'b0000;

    always_ff @(posedge clk_sys) begin
        if (beat_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) ram[ram_idx][8*b +: 8] <= data_write[8*b +: 8];
            end
            ram_q <= ram[ram_idx];
        end
    end

    assign data_read = ack ? ram_q : 32'h0;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            ack          <= 1'b0;
            err          <= 1'b0;
            access_count <= 16'h0;
            idx_q        <= '0;
            wait_cnt     <= 3'd0;
        end else begin
            ack <= beat_fire;
            err <= err_fire;
            if (beat_fire) access_count <= access_count + 16'd1;
            case (state)
                S_IDLE: begin
                    if (req) begin
                        idx_q <= {1'b0, offset[AW-1:0]} + IDX_ONE;
                        if (err_fire) begin
                            state <= S_ERR;
                        end else if (cti == CTI_INCR) begin
                            state <= S_BURST;
                        end else if (beat_fire) begin
                            state <= S_ACK;
                        end else begin
                            state    <= S_WAIT;
                            idx_q    <= {1'b0, offset[AW-1:0]};
                            wait_cnt <= 3'(WAIT_STATES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!cyc)           state <= S_IDLE;
                    else if (beat_fire) state <= S_ACK;
                    else                wait_cnt <= wait_cnt - 3'd1;
                end
                S_BURST: begin
                    if (!cyc) begin
                        state <= S_IDLE;
                    end else if (err_fire) begin
                        state <= S_ERR;
                    end else if (beat_fire) begin
                        idx_q <= idx_q + IDX_ONE;
                        if (cti == CTI_END) state <= S_ACK;
                    end
                end
                S_ACK:   state <= S_DEAD;
                S_ERR:   state <= S_DEAD;
                S_DEAD:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apf_wishbone_ram_slave.sv
// Self-checking bench: two responders (no wait states at a nonzero base, and 3 wait states at base 0),
// read data checked against a scoreboard queue fed from a bench-side memory model.
module tb_apf_wishbone_ram_slave;
    localparam logic [29:0] BASE0 = 30'h0000_1000;
    localparam logic [29:0] BASE3 = 30'h0;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] data_write = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        cyc0 = 1'b0, stb0 = 1'b0, cyc3 = 1'b0, stb3 = 1'b0;
    logic [31:0] data_read0, data_read3;
    logic        ack0, err0, ack3, err3;
    logic [15:0] access_count0, access_count3;

    int nassert = 0;
    int nfail = 0;
    int cnt0 = 0;
    int cnt3 = 0;
    logic [31:0] model0 [256];
    logic [31:0] model3 [256];
    logic [31:0] exp_q [$];

    always #5 clk_sys = ~clk_sys;

    apf_wishbone_ram_slave #(.ADDR_WORDS_LOG2(8), .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
        .clk_sys(clk_sys), .reset_n(reset_n), .addr(addr), .data_write(data_write), .sel(sel),
        .cyc(cyc0), .stb(stb0), .we(we), .cti(cti), .bte(bte),
        .data_read(data_read0), .ack(ack0), .err(err0), .access_count(access_count0));

    apf_wishbone_ram_slave #(.ADDR_WORDS_LOG2(8), .BASE_ADDR(BASE3), .WAIT_STATES(3)) dut3 (
        .clk_sys(clk_sys), .reset_n(reset_n), .addr(addr), .data_write(data_write), .sel(sel),
        .cyc(cyc3), .stb(stb3), .we(we), .cti(cti), .bte(bte),
        .data_read(data_read3), .ack(ack3), .err(err3), .access_count(access_count3));

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One classic (or single-beat error) access; starts and ends at an idle cycle.
    task automatic bus_cycle(input bit u3, input bit wr, input logic [29:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [2:0] c, input logic [1:0] b,
                             input int exp_lat, input bit exp_err, input string nm);
        int lat;
        bit got_ack, got_err;
        logic [31:0] dr, expv;
        logic [29:0] off;
        off = a - (u3 ? BASE3 : BASE0);
        if (!wr && !exp_err) exp_q.push_back(u3 ? model3[off[7:0]] : model0[off[7:0]]);
        addr = a; data_write = d; sel = s; we = wr; cti = c; bte = b;
        if (u3) begin cyc3 = 1'b1; stb3 = 1'b1; end else begin cyc0 = 1'b1; stb0 = 1'b1; end
        lat = -1; got_ack = 1'b0; got_err = 1'b0; dr = '0;
        for (int n = 1; n <= exp_lat + 4; n++) begin
            tick();
            got_ack = u3 ? ack3 : ack0;
            got_err = u3 ? err3 : err0;
            dr = u3 ? data_read3 : data_read0;
            if (got_ack || got_err) begin
                lat = n;
                break;
            end
        end
        cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0; cti = '0; bte = '0;
        nassert++;
        if (lat !== exp_lat) begin
            nfail++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", nm, lat, exp_lat);
        end
        nassert++;
        if (got_err !== exp_err || got_ack !== !exp_err) begin
            nfail++;
            $display("FAIL %s termination: ack=%0b err=%0b, expected err=%0b", nm, got_ack, got_err, exp_err);
        end
        if (got_ack) begin
            if (u3) cnt3++; else cnt0++;
            if (wr) begin
                if (u3) model3[off[7:0]] = merge(model3[off[7:0]], d, s);
                else    model0[off[7:0]] = merge(model0[off[7:0]], d, s);
            end else begin
                nassert++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL %s data: got %h, expected no read ack", nm, dr);
                end else begin
                    expv = exp_q.pop_front();
                    if (dr !== expv) begin
                        nfail++;
                        $display("FAIL %s data: got %h, expected %h", nm, dr, expv);
                    end
                end
            end
        end else if (!wr && !exp_err && exp_q.size() > 0) begin
            void'(exp_q.pop_back());
        end
        tick();
        nassert++;
        if ((u3 ? ack3 : ack0) !== 1'b0 || (u3 ? err3 : err0) !== 1'b0) begin
            nfail++;
            $display("FAIL %s dead cycle: ack=%0b err=%0b, expected 0 0", nm, u3 ? ack3 : ack0, u3 ? err3 : err0);
        end
        nassert++;
        if ((u3 ? access_count3 : access_count0) !== 16'(u3 ? cnt3 : cnt0)) begin
            nfail++;
            $display("FAIL %s access_count: got %0d, expected %0d", nm, u3 ? access_count3 : access_count0, u3 ? cnt3 : cnt0);
        end
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        nassert++;
        if ({ack0, err0, ack3, err3} !== 4'b0 || data_read0 !== 32'h0 || access_count0 !== 16'h0 || access_count3 !== 16'h0) begin
            nfail++;
            $display("FAIL reset values: ack0=%0b err0=%0b dr0=%h cnt0=%0d cnt3=%0d, expected all zero",
                     ack0, err0, data_read0, access_count0, access_count3);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_classic();
        bus_cycle(0, 1, BASE0 + 30'd3, 32'hDEADBEEF, 4'hF, 3'b000, 2'b00, 1, 0, "classic_write");
        bus_cycle(0, 0, BASE0 + 30'd3, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "classic_read");
        bus_cycle(0, 1, BASE0 + 30'd0, 32'h0BADF00D, 4'hF, 3'b111, 2'b00, 1, 0, "classic_write_w0");
        bus_cycle(0, 0, BASE0 + 30'd0, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "classic_read_w0");
    endtask

    task automatic test_byte_lanes();
        bus_cycle(0, 1, BASE0 + 30'd8, 32'h11223344, 4'hF, 3'b000, 2'b00, 1, 0, "bytes_full");
        bus_cycle(0, 1, BASE0 + 30'd8, 32'h000000AA, 4'h1, 3'b000, 2'b00, 1, 0, "bytes_lane0");
        bus_cycle(0, 0, BASE0 + 30'd8, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "bytes_read");
        bus_cycle(0, 1, BASE0 + 30'd8, 32'h5A5A0000, 4'hC, 3'b000, 2'b00, 1, 0, "bytes_upper");
        bus_cycle(0, 1, BASE0 + 30'd8, 32'hFFFFFFFF, 4'h0, 3'b000, 2'b00, 1, 0, "bytes_sel0");
        bus_cycle(0, 0, BASE0 + 30'd8, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "bytes_read2");
    endtask

    task automatic test_errors();
        bus_cycle(0, 0, BASE0 + 30'd256, 32'h0, 4'hF, 3'b000, 2'b00, 1, 1, "err_above");
        bus_cycle(0, 1, BASE0 - 30'd1, 32'h12345678, 4'hF, 3'b000, 2'b00, 1, 1, "err_below");
        bus_cycle(0, 0, BASE0 + 30'd1, 32'h0, 4'hF, 3'b010, 2'b01, 1, 1, "err_bte");
        bus_cycle(0, 0, BASE0 + 30'd255, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "last_word_read_setup");
    endtask

    task automatic test_burst_read();
        bit          stb_t [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  cti_t [6] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b111};
        logic [31:0] expv;
        for (int w = 4; w < 8; w++)
            bus_cycle(0, 1, BASE0 + 30'(w), 32'hB0000000 + 32'(w * 32'h01010101), 4'hF, 3'b000, 2'b00, 1, 0, "burst_fill");
        for (int w = 4; w < 8; w++) exp_q.push_back(model0[w]);
        addr = BASE0 + 30'd4; we = 1'b0; sel = 4'hF; bte = 2'b00; cyc0 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            stb0 = stb_t[i];
            cti = cti_t[i];
            if (i > 0) addr = 30'h3FFF_FFF0;
            tick();
            nassert++;
            if (ack0 !== stb_t[i] || err0 !== 1'b0) begin
                nfail++;
                $display("FAIL burst_beat%0d: ack=%0b err=%0b, expected ack=%0b err=0", i, ack0, err0, stb_t[i]);
            end
            if (ack0 === 1'b1 && exp_q.size() > 0) begin
                expv = exp_q.pop_front();
                nassert++;
                if (data_read0 !== expv) begin
                    nfail++;
                    $display("FAIL burst_data%0d: got %h, expected %h", i, data_read0, expv);
                end
            end
        end
        cnt0 += 4;
        cyc0 = 1'b0; stb0 = 1'b0; cti = '0;
        tick();
        nassert++;
        if (ack0 !== 1'b0 || err0 !== 1'b0 || access_count0 !== 16'(cnt0)) begin
            nfail++;
            $display("FAIL burst_dead: ack=%0b err=%0b count=%0d, expected 0 0 %0d", ack0, err0, access_count0, cnt0);
        end
        // strobe presented during the dead cycle is taken one cycle later, from IDLE
        bus_cycle(0, 0, BASE0 + 30'd5, 32'h0, 4'hF, 3'b000, 2'b00, 2, 0, "after_burst_read");
    endtask

    task automatic test_burst_wrap();
        logic [31:0] expv;
        bus_cycle(0, 1, BASE0 + 30'd255, 32'hFEEDFACE, 4'hF, 3'b000, 2'b00, 1, 0, "wrap_fill");
        exp_q.push_back(model0[255]);
        addr = BASE0 + 30'd255; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00;
        cyc0 = 1'b1; stb0 = 1'b1;
        tick();
        nassert++;
        expv = exp_q.pop_front();
        if (ack0 !== 1'b1 || err0 !== 1'b0 || data_read0 !== expv) begin
            nfail++;
            $display("FAIL wrap_first: ack=%0b err=%0b data=%h, expected 1 0 %h", ack0, err0, data_read0, expv);
        end
        tick();
        nassert++;
        if (ack0 !== 1'b0 || err0 !== 1'b1) begin
            nfail++;
            $display("FAIL wrap_err: ack=%0b err=%0b, expected 0 1", ack0, err0);
        end
        cnt0 += 1;
        cyc0 = 1'b0; stb0 = 1'b0; cti = '0;
        tick();
        nassert++;
        if (ack0 !== 1'b0 || err0 !== 1'b0 || access_count0 !== 16'(cnt0)) begin
            nfail++;
            $display("FAIL wrap_dead: ack=%0b err=%0b count=%0d, expected 0 0 %0d", ack0, err0, access_count0, cnt0);
        end
        tick();
    endtask

    task automatic test_wait_states();
        bit seen;
        bus_cycle(1, 1, 30'd5, 32'hCAFEF00D, 4'hF, 3'b000, 2'b00, 4, 0, "wait_write");
        bus_cycle(1, 0, 30'd5, 32'h0, 4'hF, 3'b000, 2'b00, 4, 0, "wait_read");
        for (int k = 0; k < 2; k++) begin
            addr = 30'd5; data_write = 32'hBAD0BAD0; sel = 4'hF; we = (k == 1); cti = '0; bte = '0;
            cyc3 = 1'b1; stb3 = 1'b1;
            tick();
            tick();
            cyc3 = 1'b0; stb3 = 1'b0; we = 1'b0;
            seen = 1'b0;
            for (int n = 0; n < 6; n++) begin
                tick();
                if (ack3 === 1'b1 || err3 === 1'b1) seen = 1'b1;
            end
            nassert++;
            if (seen !== 1'b0 || access_count3 !== 16'(cnt3)) begin
                nfail++;
                $display("FAIL wait_abort%0d: response seen=%0b count=%0d, expected 0 %0d", k, seen, access_count3, cnt3);
            end
        end
        bus_cycle(1, 0, 30'd5, 32'h0, 4'hF, 3'b000, 2'b00, 4, 0, "wait_read_after_abort");
        bus_cycle(1, 1, 30'd5, 32'h12345678, 4'hF, 3'b000, 2'b00, 4, 0, "wait_write2");
        bus_cycle(1, 0, 30'd5, 32'h0, 4'hF, 3'b000, 2'b00, 4, 0, "wait_read2");
    endtask

    task automatic test_reset_mid_burst();
        bus_cycle(0, 1, BASE0 + 30'd10, 32'h0A0A0A0A, 4'hF, 3'b000, 2'b00, 1, 0, "rst_fill10");
        bus_cycle(0, 1, BASE0 + 30'd11, 32'h0B0B0B0B, 4'hF, 3'b000, 2'b00, 1, 0, "rst_fill11");
        addr = BASE0 + 30'd10; data_write = 32'h5555AAAA; sel = 4'hF; we = 1'b1; cti = 3'b010; bte = '0;
        cyc0 = 1'b1; stb0 = 1'b1;
        tick();
        nassert++;
        if (ack0 !== 1'b1) begin
            nfail++;
            $display("FAIL rst_first_beat: ack=%0b, expected 1", ack0);
        end
        model0[10] = 32'h5555AAAA;
        data_write = 32'h66667777;
        #2 reset_n = 1'b0;
        #1;
        cnt0 = 0;
        cnt3 = 0;
        nassert++;
        if (ack0 !== 1'b0 || err0 !== 1'b0 || access_count0 !== 16'h0 || data_read0 !== 32'h0) begin
            nfail++;
            $display("FAIL rst_async: ack=%0b err=%0b count=%0d data=%h, expected 0 0 0 0", ack0, err0, access_count0, data_read0);
        end
        tick();
        cyc0 = 1'b0; stb0 = 1'b0; we = 1'b0; cti = '0;
        reset_n = 1'b1;
        tick();
        bus_cycle(0, 0, BASE0 + 30'd11, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "rst_read11");
        bus_cycle(0, 0, BASE0 + 30'd10, 32'h0, 4'hF, 3'b000, 2'b00, 1, 0, "rst_read10");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_classic();
        test_byte_lanes();
        test_errors();
        test_burst_read();
        test_burst_wrap();
        test_wait_states();
        test_reset_mid_burst();
        nassert++;
        if (exp_q.size() != 0) begin
            nfail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
